// File: rtl/fetch_prefetch_pkg.sv
// Shared constants and types for the prefetching fetch unit.
package fetch_prefetch_pkg;

    // RAM bus geometry
    localparam int unsigned RAM_AWIDTH = 32;
    localparam int unsigned RAM_DWIDTH = 32;
    localparam int unsigned RAM_LWIDTH = 8;

    // Fetch FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    // Instruction presented to the decoder when nothing is buffered (addi x0, x0, 0)
    localparam logic [31:0] NOP = 32'h0000_0013;

    // One prefetch buffer entry
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are ignored
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs; flush wins over push and pop.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, no reset needed: entries are only read once count says they are valid
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Prefetching fetch unit: issues burst reads ahead of the decoder and buffers {pc, instr}.
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int unsigned AWIDTH    = RAM_AWIDTH,
    parameter int unsigned DWIDTH    = RAM_DWIDTH,
    parameter int unsigned LWIDTH    = RAM_LWIDTH,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned BURST_LEN = 4,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_code,
    output logic [31:0]       inst_pc,
    output logic [AWIDTH-1:0] ram_araddr,
    output logic [LWIDTH-1:0] ram_arlen,
    output logic              ram_arvalid,
    input  logic              ram_arready,
    input  logic [DWIDTH-1:0] ram_rdata,
    input  logic              ram_rvalid,
    output logic              ram_rready,
    input  logic              ram_rlast,
    output logic [AWIDTH-1:0] ram_awaddr,
    output logic [LWIDTH-1:0] ram_awlen,
    output logic              ram_awvalid,
    output logic [DWIDTH-1:0] ram_wdata,
    output logic              ram_wready,
    input  logic              ram_awready,
    input  logic              ram_wvalid,
    input  logic              ram_wlast
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned BW = $clog2(BURST_LEN + 1);

    logic [1:0]        state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       beat_pc_q, beat_pc_d;
    logic [AWIDTH-1:0] araddr_q, araddr_d;
    logic              discard_q, discard_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;

    logic              push;
    logic              pop;
    logic              space_ok;
    logic [31:0]       redir_pc;
    logic [CW-1:0]     count;
    logic              fifo_full;
    logic              fifo_empty;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign redir_pc = word_align(redirect_pc);
    // A whole burst must fit, so space is reserved before the request goes out
    assign space_ok = (count <= CW'(DEPTH - BURST_LEN));

    // Next-state logic for the fetch FSM, pcs and discard flag; redirect overrides everything
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        beat_pc_d  = beat_pc_q;
        araddr_d   = araddr_q;
        discard_d  = discard_q;
        beat_cnt_d = beat_cnt_q;
        push       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                end else if (space_ok) begin
                    araddr_d   = AWIDTH'(fetch_pc_q);
                    beat_pc_d  = fetch_pc_q;
                    beat_cnt_d = '0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                // The address stays put until accepted; a redirect only marks the burst stale
                if (ram_arready) state_d = ST_BURST;
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                    discard_d  = 1'b1;
                end
            end
            ST_BURST: begin
                if (ram_rvalid) begin
                    beat_pc_d = beat_pc_q + 32'd4;
                    push      = !discard_q && !redirect_valid &&
                                (beat_cnt_q < BW'(BURST_LEN));
                    if (beat_cnt_q < BW'(BURST_LEN)) beat_cnt_d = beat_cnt_q + 1'b1;
                    if (ram_rlast) begin
                        state_d   = ST_IDLE;
                        discard_d = 1'b0;
                        if (!discard_q) fetch_pc_d = beat_pc_q + 32'd4;
                    end
                end
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                    // Nothing left to drop when the redirect lands on the final beat
                    discard_d  = !(ram_rvalid && ram_rlast);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Fetch state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            beat_pc_q  <= RESET_PC;
            araddr_q   <= '0;
            discard_q  <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            beat_pc_q  <= beat_pc_d;
            araddr_q   <= araddr_d;
            discard_q  <= discard_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign push_entry = '{pc: beat_pc_q, instr: 32'(ram_rdata)};
    assign pop        = inst_valid && inst_ready;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (push_entry),
        .dout  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign inst_valid  = !fifo_empty;
    assign inst_code   = inst_valid ? head.instr : NOP;
    assign inst_pc     = inst_valid ? head.pc : 32'h0;

    assign ram_araddr  = araddr_q;
    assign ram_arlen   = LWIDTH'(BURST_LEN - 1);
    assign ram_arvalid = (state_q == ST_REQ);
    assign ram_rready  = (state_q == ST_BURST);

    // Read-only master: write channel held idle
    assign ram_awaddr  = '0;
    assign ram_awlen   = '0;
    assign ram_awvalid = 1'b0;
    assign ram_wdata   = '0;
    assign ram_wready  = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{ram_awready, ram_wvalid, ram_wlast, fifo_full};

endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomized bench for fetch_prefetch with a RAM responder and an instruction-stream model.
module tb_fetch_prefetch;
    import fetch_prefetch_pkg::*;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned BURST_LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_code;
    logic [31:0] inst_pc;
    logic [31:0] ram_araddr;
    logic [7:0]  ram_arlen;
    logic        ram_arvalid;
    logic        ram_arready = 1'b0;
    logic [31:0] ram_rdata = '0;
    logic        ram_rvalid = 1'b0;
    logic        ram_rready;
    logic        ram_rlast = 1'b0;
    logic [31:0] ram_awaddr;
    logic [7:0]  ram_awlen;
    logic        ram_awvalid;
    logic [31:0] ram_wdata;
    logic        ram_wready;

    always #5 clk = ~clk;

    fetch_prefetch #(
        .DEPTH     (DEPTH),
        .BURST_LEN (BURST_LEN),
        .RESET_PC  (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_code      (inst_code),
        .inst_pc        (inst_pc),
        .ram_araddr     (ram_araddr),
        .ram_arlen      (ram_arlen),
        .ram_arvalid    (ram_arvalid),
        .ram_arready    (ram_arready),
        .ram_rdata      (ram_rdata),
        .ram_rvalid     (ram_rvalid),
        .ram_rready     (ram_rready),
        .ram_rlast      (ram_rlast),
        .ram_awaddr     (ram_awaddr),
        .ram_awlen      (ram_awlen),
        .ram_awvalid    (ram_awvalid),
        .ram_wdata      (ram_wdata),
        .ram_wready     (ram_wready),
        .ram_awready    (1'b0),
        .ram_wvalid     (1'b0),
        .ram_wlast      (1'b0)
    );

    int checks   = 0;
    int failures = 0;

    // Stimulus knobs (percent probabilities and directed triggers)
    int p_ready, p_arready, p_rvalid, p_redir;
    int redir_beat     = -1;
    bit redir_on_last  = 1'b0;
    bit force_redir    = 1'b0;

    // RAM responder state
    bit          ram_busy;
    logic [31:0] ram_addr;
    int          ram_beat;

    // Reference model: the decoder must see a contiguous pc stream from the latest redirect
    logic [31:0] exp_pc;
    logic [31:0] next_fetch;
    int          occ;
    bit          tainted;
    bit          prev_arvalid;
    logic [31:0] prev_araddr;
    int          idle_run;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    task automatic model_reset();
        ram_busy     = 1'b0;
        ram_addr     = '0;
        ram_beat     = 0;
        exp_pc       = 32'h0;
        next_fetch   = 32'h0;
        occ          = 0;
        tainted      = 1'b0;
        prev_arvalid = 1'b0;
        prev_araddr  = '0;
        idle_run     = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_arvalid"}, 32'(ram_arvalid), 32'd0);
        check_eq({tag, "_araddr"}, ram_araddr, 32'd0);
        check_eq({tag, "_rready"}, 32'(ram_rready), 32'd0);
        check_eq({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        check_eq({tag, "_inst_code"}, inst_code, NOP);
        check_eq({tag, "_inst_pc"}, inst_pc, 32'd0);
    endtask

    // Drive all inputs for the cycle just started
    task automatic drive();
        logic [31:0] r;
        ram_arready = ($urandom % 100) < p_arready;
        ram_rvalid  = ram_busy && (($urandom % 100) < p_rvalid);
        ram_rdata   = ram_rvalid ? word_at(ram_addr + 32'(ram_beat) * 32'd4) : $urandom;
        ram_rlast   = ram_rvalid && (ram_beat == BURST_LEN - 1);
        inst_ready  = ($urandom % 100) < p_ready;
        redirect_valid = ($urandom % 100) < p_redir;
        if (redir_beat >= 0 && ram_rvalid && ram_beat == redir_beat) redirect_valid = 1'b1;
        if (redir_on_last && ram_rlast) begin
            redirect_valid = 1'b1;
            inst_ready     = 1'b1;
        end
        if (force_redir) begin
            redirect_valid = 1'b1;
            force_redir    = 1'b0;
        end
        r = $urandom;
        redirect_pc = (r[3:0] == 4'h0) ? (32'hFFFF_FFF0 | 32'(r[5:4])) : (r & 32'h0000_FFFF);
    endtask

    // Check the settled outputs of this cycle, then advance the model by the upcoming edge
    task automatic sample();
        bit          pop, push, hs_r, hs_ar, outstanding;
        logic [31:0] rp;
        check_eq("arlen", 32'(ram_arlen), BURST_LEN - 1);
        check_eq("aw_ties", 32'(|{ram_awaddr, ram_awlen, ram_awvalid, ram_wdata, ram_wready}), 0);
        check_eq("rready", 32'(ram_rready), 32'(ram_busy));
        check_eq("inst_valid", 32'(inst_valid), 32'(occ > 0));
        if (!inst_valid) begin
            check_eq("nop_code", inst_code, NOP);
            check_eq("nop_pc", inst_pc, 32'd0);
        end
        if (ram_arvalid && !prev_arvalid) begin
            check_eq("araddr", ram_araddr, next_fetch);
            check_eq("space", 32'(occ <= int'(DEPTH - BURST_LEN)), 32'd1);
        end else if (ram_arvalid) begin
            check_eq("araddr_hold", ram_araddr, prev_araddr);
        end
        if (redirect_valid || ram_arvalid || ram_busy || occ > int'(DEPTH - BURST_LEN)) begin
            idle_run = 0;
        end else begin
            idle_run++;
            check_eq("ar_issue", 32'(idle_run <= 1), 32'd1);
        end

        pop  = inst_valid && inst_ready && !redirect_valid;
        if (pop) begin
            check_eq("inst_pc", inst_pc, exp_pc);
            check_eq("inst_code", inst_code, word_at(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        hs_r  = ram_rvalid && ram_rready;
        hs_ar = ram_arvalid && ram_arready;
        outstanding = ram_arvalid || (ram_busy && !(hs_r && ram_rlast));
        push = hs_r && !tainted && !redirect_valid;
        occ  = redirect_valid ? 0 : occ + int'(push) - int'(pop);

        if (hs_r) begin
            ram_beat++;
            if (ram_rlast) begin
                ram_busy = 1'b0;
                if (!tainted && !redirect_valid) next_fetch = next_fetch + 32'd16;
                tainted = 1'b0;
            end
        end
        if (hs_ar) begin
            ram_busy = 1'b1;
            ram_addr = ram_araddr;
            ram_beat = 0;
        end
        if (redirect_valid) begin
            rp         = {redirect_pc[31:2], 2'b00};
            exp_pc     = rp;
            next_fetch = rp;
            if (outstanding) tainted = 1'b1;
        end
        prev_arvalid = ram_arvalid;
        prev_araddr  = ram_araddr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_knobs(input int rdy, input int arr, input int rv, input int rd);
        p_ready   = rdy;
        p_arready = arr;
        p_rvalid  = rv;
        p_redir   = rd;
    endtask

    initial begin
        bit found;
        model_reset();
        set_knobs(100, 100, 100, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Zero-wait RAM with an always-ready decoder
        run(40);

        // Decoder stalls: buffer fills, requests stop, then resume once drained
        set_knobs(0, 100, 100, 0);
        run(40);
        check_eq("filled", 32'(inst_valid), 32'd1);
        set_knobs(100, 100, 100, 0);
        run(30);

        // Redirect on the second beat of a burst
        set_knobs(70, 70, 80, 0);
        redir_beat = 1;
        run(80);
        redir_beat = -1;

        // Redirect while the request is held off by arready
        set_knobs(100, 0, 100, 0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            found = ram_arvalid;
        end
        check_eq("wait_arvalid", 32'(found), 32'd1);
        force_redir = 1'b1;
        run(5);
        set_knobs(100, 100, 100, 0);
        run(30);

        // Redirect coincident with rlast and a pop
        set_knobs(100, 80, 80, 0);
        redir_on_last = 1'b1;
        run(80);
        redir_on_last = 1'b0;

        // Mixed random traffic
        set_knobs(60, 60, 70, 3);
        run(2000);
        set_knobs(20, 90, 90, 2);
        run(1000);

        // Asynchronous reset in the middle of a burst
        set_knobs(100, 100, 60, 0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            found = ram_busy && ram_beat >= 1;
        end
        check_eq("wait_midburst", 32'(found), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        ram_rvalid     = 1'b0;
        ram_rlast      = 1'b0;
        ram_arready    = 1'b0;
        redirect_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        set_knobs(70, 70, 70, 2);
        run(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
